// File: rtl/jchk_pkg.sv
// Shared types and helpers for the Johnson stream checker.
// JCHK_STAGES_OUT_EN enables the reconstructed stage_out port on the top.
package jchk_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } jchk_state_t;

  function automatic int phase_w(input int stages);
    return $clog2(2 * stages);
  endfunction

  function automatic logic expect_bit(
    input int ph,
    input int stages
  );
    return ph < stages;
  endfunction

  function automatic logic stage_bit(
    input int ph,
    input int k,
    input int stages
  );
    int d;
    d = (ph - k + 2 * stages) % (2 * stages);
    return d < stages;
  endfunction

endpackage

// File: rtl/jchk_run_detect.sv
// Run-length acquisition: reports when a ones-run and a zeros-run
// of exactly STAGES bits have been seen back to back.
module jchk_run_detect
  import jchk_pkg::*;
#(
  parameter int STAGES = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  logic i_search,
  input  logic i_seed,
  input  logic i_bit,
  output logic o_acq_hit,
  output logic o_acq_bit
);

  localparam int RW = $clog2(STAGES + 2);
  localparam logic [RW-1:0] RUN_FULL = RW'(STAGES);
  localparam logic [RW-1:0] RUN_MAX = RW'(STAGES + 1);

  logic          r_prev;
  logic [RW-1:0] r_run_len;
  logic          r_first;
  logic [1:0]    r_good;

  logic w_trans;
  logic w_run_ok;

  always_comb begin
    w_trans = i_valid && i_search &&
              (r_run_len != '0) &&
              (i_bit != r_prev);
    w_run_ok = (r_run_len == RUN_FULL);
    o_acq_hit = w_trans && !r_first &&
                w_run_ok && (r_good == 2'd1);
    o_acq_bit = i_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev    <= 1'b0;
      r_run_len <= '0;
      r_first   <= 1'b1;
      r_good    <= 2'd0;
    end else if (i_seed) begin
      r_prev    <= i_bit;
      r_run_len <= RW'(1);
      r_first   <= 1'b1;
      r_good    <= 2'd0;
    end else if (i_valid && i_search) begin
      r_prev <= i_bit;
      if (w_trans) begin
        r_run_len <= RW'(1);
        r_first   <= 1'b0;
        // a leading partial run is never judged
        if (r_first)
          r_good <= r_good;
        else if (o_acq_hit || !w_run_ok)
          r_good <= 2'd0;
        else
          r_good <= r_good + 2'd1;
      end else if (r_run_len != RUN_MAX) begin
        r_run_len <= r_run_len + RW'(1);
      end
    end
  end

endmodule

// File: rtl/johnson_stream_checker.sv
// Johnson stream checker: acquires lock, flywheels phase, counts errors.
// Define JCHK_STAGES_OUT_EN to add the stage_out reconstruction port.
module johnson_stream_checker
  import jchk_pkg::*;
#(
  parameter int STAGES      = 7,
  parameter int ERR_W       = 8,
  parameter int LOSS_THRESH = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  input  logic                          clear_err,
  output logic                          locked,
  output logic [$clog2(2*STAGES)-1:0]   phase,
  output logic                          bit_err,
  output logic [ERR_W-1:0]              err_count
`ifdef JCHK_STAGES_OUT_EN
  ,
  output logic [STAGES-1:0]             stage_out
`endif
);

  localparam int PW = phase_w(STAGES);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * STAGES - 1);
  localparam logic [PW-1:0] PH_ZRUN = PW'(STAGES);
  localparam int MW = 3;
  localparam logic [MW-1:0] MISS_LIM = MW'(LOSS_THRESH);

  jchk_state_t      r_state;
  logic [PW-1:0]    r_phase;
  logic             r_bit_err;
  logic [ERR_W-1:0] r_err;
  logic [MW-1:0]    r_miss;

  jchk_state_t      w_state_n;
  logic [PW-1:0]    w_phase_n;
  logic [PW-1:0]    w_ph_adv;
  logic [MW-1:0]    w_miss_n;
  logic [MW-1:0]    w_miss_inc;
  logic [ERR_W-1:0] w_err_n;
  logic             w_pulse;
  logic             w_seed;
  logic             w_exp;
  logic             w_acq_hit;
  logic             w_acq_bit;

  jchk_run_detect #(
    .STAGES(STAGES)
  ) u_run (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (bit_valid),
    .i_search (r_state == SEARCH),
    .i_seed   (w_seed),
    .i_bit    (bit_in),
    .o_acq_hit(w_acq_hit),
    .o_acq_bit(w_acq_bit)
  );

  always_comb begin
    w_state_n  = r_state;
    w_phase_n  = r_phase;
    w_miss_n   = r_miss;
    w_pulse    = 1'b0;
    w_seed     = 1'b0;
    w_ph_adv   = (r_phase == PH_LAST) ?
                 '0 : r_phase + PW'(1);
    w_exp      = expect_bit(int'(w_ph_adv), STAGES);
    w_miss_inc = r_miss + MW'(1);
    if (bit_valid) begin
      unique case (r_state)
        SEARCH: begin
          if (w_acq_hit) begin
            w_state_n = LOCKED;
            w_phase_n = w_acq_bit ? '0 : PH_ZRUN;
            w_miss_n  = '0;
          end
        end
        LOCKED: begin
          w_phase_n = w_ph_adv;
          if (bit_in == w_exp) begin
            w_miss_n = '0;
          end else begin
            w_pulse  = 1'b1;
            w_miss_n = w_miss_inc;
            if (w_miss_inc == MISS_LIM) begin
              w_state_n = SEARCH;
              w_phase_n = '0;
              w_miss_n  = '0;
              w_seed    = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // a clear coinciding with an error keeps that error
  always_comb begin
    w_err_n = r_err;
    if (clear_err)
      w_err_n = ERR_W'(w_pulse);
    else if (w_pulse && (r_err != '1))
      w_err_n = r_err + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SEARCH;
      r_phase   <= '0;
      r_bit_err <= 1'b0;
      r_err     <= '0;
      r_miss    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_phase   <= w_phase_n;
      r_bit_err <= w_pulse;
      r_err     <= w_err_n;
      r_miss    <= w_miss_n;
    end
  end

  assign locked    = (r_state == LOCKED);
  assign phase     = r_phase;
  assign bit_err   = r_bit_err;
  assign err_count = r_err;

`ifdef JCHK_STAGES_OUT_EN
  logic [STAGES-1:0] r_stage;
  logic [STAGES-1:0] w_stage_n;

  always_comb begin
    w_stage_n = '0;
    for (int k = 0; k < STAGES; k++)
      w_stage_n[k] = (w_state_n == LOCKED) &&
        stage_bit(int'(w_phase_n), k, STAGES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stage <= '0;
    else
      r_stage <= w_stage_n;
  end

  assign stage_out = r_stage;
`endif

endmodule

// File: tb/tb_johnson_stream_checker.sv
// Directed scoreboard bench for johnson_stream_checker (STAGES=7).
// Covers acquisition, flywheel errors, loss of lock, gaps, saturation.
module tb_johnson_stream_checker;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       clear_err;
  logic       locked;
  logic [3:0] phase;
  logic       bit_err;
  logic [7:0] err_count;
`ifdef JCHK_STAGES_OUT_EN
  logic [6:0] stage_out;
`endif

  johnson_stream_checker #(
    .STAGES(7),
    .ERR_W(8),
    .LOSS_THRESH(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clear_err(clear_err),
    .locked   (locked),
    .phase    (phase),
    .bit_err  (bit_err),
    .err_count(err_count)
`ifdef JCHK_STAGES_OUT_EN
    ,
    .stage_out(stage_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       lk;
    logic [3:0] ph;
    logic       be;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int fails  = 0;

  logic       m_lk;
  logic [3:0] m_ph;
  logic [7:0] m_err;
  int         m_miss;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h",
             tag, got, want);
    end
  endtask

  function automatic logic [3:0] ph_next();
    return (m_ph == 4'd13) ? 4'd0 : m_ph + 4'd1;
  endfunction

  function automatic logic nxt_bit();
    return ph_next() < 4'd7;
  endfunction

  task automatic step(
    input logic b,
    input logic v,
    input logic clr,
    input logic acq
  );
    logic pulse;
    exp_t e;
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    clear_err = clr;
    pulse     = 1'b0;
    if (v) begin
      if (m_lk) begin
        if (b != nxt_bit()) begin
          pulse = 1'b1;
          m_miss++;
        end else begin
          m_miss = 0;
        end
        m_ph = ph_next();
        if (m_miss == 3) begin
          m_lk   = 1'b0;
          m_ph   = 4'd0;
          m_miss = 0;
        end
      end else if (acq) begin
        m_lk   = 1'b1;
        m_ph   = b ? 4'd0 : 4'd7;
        m_miss = 0;
      end
    end
    if (clr)
      m_err = {7'd0, pulse};
    else if (pulse && m_err != 8'hff)
      m_err = m_err + 8'd1;
    q.push_back('{m_lk, m_ph, pulse, m_err});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("locked", 32'(locked), 32'(e.lk));
    chk("phase", 32'(phase), 32'(e.ph));
    chk("bit_err", 32'(bit_err), 32'(e.be));
    chk("err_count", 32'(err_count), 32'(e.ec));
`ifdef JCHK_STAGES_OUT_EN
    for (int k = 0; k < 7; k++) begin
      logic [3:0] d;
      d = (e.ph + 4'd14 - 4'(k)) % 4'd14;
      chk("stage_out", 32'(stage_out[k]),
          32'(e.lk && (d < 4'd7)));
    end
`endif
  endtask

  task automatic send_good();
    step(nxt_bit(), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_bad();
    step(~nxt_bit(), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_lk   = 1'b0;
    m_ph   = 4'd0;
    m_err  = 8'd0;
    m_miss = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clear_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_bit_err", 32'(bit_err), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lock: 3 ones, 7 zeros, 7 ones, then 0
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (6) send_good();

    // random gaps while locked
    repeat (40) begin
      if ($urandom_range(0, 2) == 0)
        step(1'($urandom_range(0, 1)),
             1'b0, 1'b0, 1'b0);
      send_good();
    end

    // single flip
    send_bad();
    repeat (3) send_good();

    // async reset mid-lock, right after an error pulse
    send_bad();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_phase", 32'(phase), 32'd0);
    chk("arst_bit_err", 32'(bit_err), 32'd0);
    chk("arst_err", 32'(err_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // bad run: partial, 7 zeros, 8 ones, 7 zeros, 7 ones
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    send_good();

    // 300 errors without losing lock
    repeat (150) begin
      send_bad();
      send_bad();
      send_good();
    end
    chk("sat_err", 32'(err_count), 32'd255);

    // clear with error, then clear during a gap
    step(~nxt_bit(), 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_good();

    // loss of lock
    repeat (3) send_bad();
    chk("loss_locked", 32'(locked), 32'd0);
    chk("loss_err", 32'(err_count), 32'd3);

    // reseeded search must not relock immediately
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
